// File: rtl/alt_vipvfr121_prc_burst_cmd_gen.sv
// -----------------------------------------------------------------------------
// alt_vipvfr121_prc_burst_cmd_gen
//
// Frame-reader command generator for the PRC read master. Each accepted
// start walks a rectangular region (base address, words per line, line count,
// line stride) and emits read burst commands of at most MAX_BURST words until
// the whole region has been requested. Only commands are produced here; read
// data returns through the read master's own path.
//
// Optional feature macro: ALT_VIPVFR121_PRC_BURST_4K_SPLIT_EN
//   When defined, burst length is further limited so that no command crosses
//   a 4 KiB address boundary. When undefined, that limiter does not exist.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   ena                           global enable; 0 freezes all state
//   start                         one-cycle frame request (seen only in IDLE)
//   abort                         synchronous cancel, wins over a same-cycle accept
//   base_addr, words_per_line,
//   num_lines, line_stride        region description, latched on start
//   busy                          frame in progress
//   done                          one-cycle pulse once every command is accepted
//   cmd, cmd_addr,
//   cmd_write_instead_of_read,
//   cmd_burst_instead_of_single_op,
//   cmd_length_of_burst           command port towards the read master
//   stall                         read master command FIFO full
//   dbg_state                     current FSM state (0 IDLE, 1 ISSUE, 2 DONE)
//
// Handshake: a command is transferred on a rising clock edge where
// cmd=1, stall=0, ena=1 and abort=0. While cmd=1 and no transfer happens,
// every cmd_* output holds its value; cmd_* depend on registers only, never
// combinationally on stall.
// -----------------------------------------------------------------------------
module alt_vipvfr121_prc_burst_cmd_gen #(
    parameter int ADDR_WIDTH                     = 32,
    parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
    parameter int MAX_BURST                      = 32,
    parameter int BYTES_PER_WORD                 = 16,
    parameter int WORDS_WIDTH                    = 16,
    parameter int LINES_WIDTH                    = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      ena,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [WORDS_WIDTH-1:0]                    words_per_line,
    input  logic [LINES_WIDTH-1:0]                    num_lines,
    input  logic [ADDR_WIDTH-1:0]                     line_stride,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      cmd,
    output logic [ADDR_WIDTH-1:0]                     cmd_addr,
    output logic                                      cmd_write_instead_of_read,
    output logic                                      cmd_burst_instead_of_single_op,
    output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] cmd_length_of_burst,
    input  logic                                      stall,
    output logic [1:0]                                dbg_state
);

    localparam int LEN_W     = MAX_BURST_LENGTH_REQUIREDWIDTH;
    // Internal length arithmetic is wide enough for the word counter, the
    // command length field and a full 4 KiB page expressed in bytes.
    localparam int CW0       = (WORDS_WIDTH > LEN_W) ? WORDS_WIDTH : LEN_W;
    localparam int CW        = (CW0 > 13) ? CW0 : 13;
    localparam int BPW_SHIFT = $clog2(BYTES_PER_WORD);
    localparam logic [CW-1:0] MAX_BURST_C = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [WORDS_WIDTH-1:0]  wpl_q;
    logic [WORDS_WIDTH-1:0]  words_left;
    logic [LINES_WIDTH-1:0]  lines_left;
    logic                    empty_q;   // frame had no words: DONE without busy

    logic [CW-1:0]           len_c;
    logic                    accept;
    logic                    line_end;
    logic                    frame_end;
    logic                    zero_region;

`ifdef ALT_VIPVFR121_PRC_BURST_4K_SPLIT_EN
    logic [12:0]             page_bytes;
    logic [CW-1:0]           page_words;
`endif

    // Burst length from registered state only.
    always_comb begin
        len_c = (CW'(words_left) < MAX_BURST_C) ? CW'(words_left) : MAX_BURST_C;
`ifdef ALT_VIPVFR121_PRC_BURST_4K_SPLIT_EN
        // Bytes left before the next 4 KiB boundary (1..4096), in words.
        page_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
        page_words = CW'(page_bytes >> BPW_SHIFT);
        if (page_words < len_c) begin
            len_c = page_words;
        end
`endif
    end

    assign zero_region = (words_per_line == '0) || (num_lines == '0);
    // abort with ena cancels the command offered in the same cycle.
    assign accept      = (state_q == S_ISSUE) && !stall && ena && !abort;
    // len never exceeds words_left, so equality marks the last burst of a line.
    assign line_end    = (CW'(words_left) == len_c);
    assign frame_end   = line_end && (lines_left == LINES_WIDTH'(1));

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_addr   <= '0;
            line_addr  <= '0;
            stride_q   <= '0;
            wpl_q      <= '0;
            words_left <= '0;
            lines_left <= '0;
            empty_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start && !abort) begin
                cur_addr   <= base_addr;
                line_addr  <= base_addr;
                stride_q   <= line_stride;
                wpl_q      <= words_per_line;
                words_left <= words_per_line;
                lines_left <= num_lines;
                empty_q    <= zero_region;
            end else if (accept && !frame_end) begin
                if (!line_end) begin
                    cur_addr   <= cur_addr + (ADDR_WIDTH'(len_c) << BPW_SHIFT);
                    words_left <= words_left - WORDS_WIDTH'(len_c);
                end else begin
                    line_addr  <= line_addr + stride_q;
                    cur_addr   <= line_addr + stride_q;
                    words_left <= wpl_q;
                    lines_left <= lines_left - LINES_WIDTH'(1);
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            if (abort) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_d = zero_region ? S_DONE : S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (accept && frame_end) begin
                            state_d = S_DONE;
                        end
                    end
                    S_DONE:  state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Outputs.
    always_comb begin
        busy                           = 1'b0;
        done                           = 1'b0;
        cmd                            = 1'b0;
        cmd_addr                       = cur_addr;
        cmd_write_instead_of_read      = 1'b0;
        cmd_burst_instead_of_single_op = 1'b0;
        cmd_length_of_burst            = '0;
        dbg_state                      = state_q;
        case (state_q)
            S_ISSUE: begin
                busy                           = 1'b1;
                cmd                            = 1'b1;
                cmd_length_of_burst            = LEN_W'(len_c);
                cmd_burst_instead_of_single_op = (len_c > CW'(1));
            end
            S_DONE: begin
                done = 1'b1;
                busy = !empty_q;
            end
            default: ;
        endcase
    end

endmodule
